mc_ctrl_fsm: RTL and testbench

//  Parametrised multicycle MIPS control unit; next generation of the controller/maindec/aludec trio.

---
 rtl/mc_ctrl_pkg.sv | 96 +++++++++
 rtl/mc_aludec.sv | 83 ++++++++
 rtl/mc_ctrl_fsm.sv | 272 +++++++++++++++++++++++++++
 tb/tb_mc_ctrl_fsm.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// mc_ctrl_pkg
// Shared definitions for the multicycle MIPS control unit:
//   - FSM state encoding (5-bit)
//   - opcode / R-type funct constants
//   - alucontrol codes and internal ALU-operation selectors
//   - pcsrc / regdst / memtoreg / alusrcb mux codes
//   - op_target(): opcode -> first execution state after DECODE
// ---------------------------------------------------------------------------
package mc_ctrl_pkg;

    typedef enum logic [4:0] {
        S_FETCH  = 5'd0,
        S_DECODE = 5'd1,
        S_MEMADR = 5'd2,
        S_MEMRD  = 5'd3,
        S_MEMWB  = 5'd4,
        S_MEMWR  = 5'd5,
        S_EXEC   = 5'd6,
        S_ALUWB  = 5'd7,
        S_IEXEC  = 5'd8,
        S_IWB    = 5'd9,
        S_BRANCH = 5'd10,
        S_JUMP   = 5'd11,
        S_JAL    = 5'd12,
        S_TRAP   = 5'd13
    } state_t;

    // Opcodes
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    // R-type funct codes
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    // alucontrol codes (native 3-bit width)
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    // Operation selector handed from the FSM to the ALU decoder
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_IMM   = 2'b11;

    // Datapath mux codes
    localparam logic [1:0] PCSRC_ALURES = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [1:0] REGDST_RT  = 2'b00;
    localparam logic [1:0] REGDST_RD  = 2'b01;
    localparam logic [1:0] REGDST_R31 = 2'b10;

    localparam logic [1:0] MEMTOREG_ALU  = 2'b00;
    localparam logic [1:0] MEMTOREG_DATA = 2'b01;
    localparam logic [1:0] MEMTOREG_PC   = 2'b10;

    localparam logic [1:0] SRCB_B    = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;
    localparam logic [1:0] SRCB_IMM2 = 2'b11;

    // State entered from DECODE for a given opcode; S_FETCH marks an
    // opcode this controller does not implement.
    function automatic state_t op_target(input logic [5:0] op);
        state_t st;
        case (op)
            OP_LW, OP_SW:                       st = S_MEMADR;
            OP_RTYPE:                           st = S_EXEC;
            OP_BEQ, OP_BNE:                     st = S_BRANCH;
            OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI:  st = S_IEXEC;
            OP_J:                               st = S_JUMP;
            OP_JAL:                             st = S_JAL;
            default:                            st = S_FETCH;
        endcase
        return st;
    endfunction

endpackage

// File: rtl/mc_aludec.sv
// ---------------------------------------------------------------------------
// mc_aludec
// Combinational ALU decoder for the multicycle MIPS controller.
// Ports:
//   i_aluop          in  2         operation class from the FSM (add/sub/funct/imm)
//   i_op             in  6         opcode, selects the immediate operation
//   i_funct          in  6         R-type funct
//   o_alucontrol     out ALUCTL_W  ALU operation code
//   o_zeroext        out 1         immediate is zero-extended (ANDI/ORI in imm class)
//   o_illegal_funct  out 1         funct is not one of add/sub/and/or/slt
// o_illegal_funct is decoded from funct alone so the write-back state can
// still suppress regwrite after the ALU class has moved on.
// ---------------------------------------------------------------------------
module mc_aludec
    import mc_ctrl_pkg::*;
#(
    parameter int ALUCTL_W = 3
) (
    input  logic [1:0]          i_aluop,
    input  logic [5:0]          i_op,
    input  logic [5:0]          i_funct,
    output logic [ALUCTL_W-1:0] o_alucontrol,
    output logic                o_zeroext,
    output logic                o_illegal_funct
);

    logic [2:0] w_fn_code;
    logic [2:0] w_imm_code;
    logic       w_imm_zext;
    logic [2:0] w_code;

    // R-type funct decode
    always_comb begin
        w_fn_code       = ALU_ADD;
        o_illegal_funct = 1'b0;
        case (i_funct)
            FN_ADD:  w_fn_code = ALU_ADD;
            FN_SUB:  w_fn_code = ALU_SUB;
            FN_AND:  w_fn_code = ALU_AND;
            FN_OR:   w_fn_code = ALU_OR;
            FN_SLT:  w_fn_code = ALU_SLT;
            default: o_illegal_funct = 1'b1;
        endcase
    end

    // Immediate-instruction decode
    always_comb begin
        w_imm_code = ALU_ADD;
        w_imm_zext = 1'b0;
        case (i_op)
            OP_ADDI: w_imm_code = ALU_ADD;
            OP_ANDI: begin
                w_imm_code = ALU_AND;
                w_imm_zext = 1'b1;
            end
            OP_ORI: begin
                w_imm_code = ALU_OR;
                w_imm_zext = 1'b1;
            end
            OP_SLTI: w_imm_code = ALU_SLT;
            default: w_imm_code = ALU_ADD;
        endcase
    end

    // Final ALU operation selection by class
    always_comb begin
        w_code    = ALU_ADD;
        o_zeroext = 1'b0;
        case (i_aluop)
            ALUOP_ADD:   w_code = ALU_ADD;
            ALUOP_SUB:   w_code = ALU_SUB;
            ALUOP_FUNCT: w_code = w_fn_code;
            ALUOP_IMM: begin
                w_code    = w_imm_code;
                o_zeroext = w_imm_zext;
            end
            default:     w_code = ALU_ADD;
        endcase
    end

    assign o_alucontrol = ALUCTL_W'(w_code);

endmodule

// File: rtl/mc_ctrl_fsm.sv
// ---------------------------------------------------------------------------
// mc_ctrl_fsm
// Multicycle MIPS control unit with memory ready/wait handshake, timeout
// (bus error), BNE/ANDI/ORI/SLTI/JAL support and sticky error flags.
//
// Build option: define MC_TRAP_EN to route illegal opcodes and memory
// timeouts through a TRAP state (pcen=1, pcsrc=TRAP_VEC_SEL). Without it
// the instruction is skipped and the FSM returns straight to FETCH.
//
// Ports:
//   clk        in   1         rising-edge clock
//   reset      in   1         asynchronous active-low reset
//   op, funct  in   6 each    instruction fields from IR
//   zero       in   1         ALU zero flag
//   mem_ready  in   1         memory completes current access
//   memreq, memwrite, iord, irwrite, pcen, pcsrc, regwrite, regdst,
//   memtoreg, alusrca, alusrcb, zeroext, alucontrol   out   datapath controls
//   bus_err    out  1         sticky memory timeout flag
//   illegal    out  1         sticky unknown opcode/funct flag
// ---------------------------------------------------------------------------
module mc_ctrl_fsm
    import mc_ctrl_pkg::*;
#(
    parameter int ALUCTL_W     = 3,
    parameter int WAIT_W       = 4,
    parameter int MEM_TIMEOUT  = 15,
    parameter int TRAP_VEC_SEL = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [5:0]          op,
    input  logic [5:0]          funct,
    input  logic                zero,
    input  logic                mem_ready,
    output logic                memreq,
    output logic                memwrite,
    output logic                iord,
    output logic                irwrite,
    output logic                pcen,
    output logic [1:0]          pcsrc,
    output logic                regwrite,
    output logic [1:0]          regdst,
    output logic [1:0]          memtoreg,
    output logic                alusrca,
    output logic [1:0]          alusrcb,
    output logic                zeroext,
    output logic [ALUCTL_W-1:0] alucontrol,
    output logic                bus_err,
    output logic                illegal
);

    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MEM_TIMEOUT);
    localparam logic [1:0]        PCSRC_TRAP = 2'(TRAP_VEC_SEL);

`ifdef MC_TRAP_EN
    localparam state_t ABORT_STATE = S_TRAP;
`else
    localparam state_t ABORT_STATE = S_FETCH;
`endif

    state_t              r_state;
    logic [WAIT_W-1:0]   r_wait;
    logic                r_bus_err;
    logic                r_illegal;

    state_t              w_next_state;
    logic                w_memreq;
    logic                w_memwrite;
    logic                w_irwrite;
    logic                w_pcen;
    logic                w_regwrite;
    logic [1:0]          w_aluop;
    logic                w_timeout;
    logic                w_set_illegal;
    logic [ALUCTL_W-1:0] w_alucontrol;
    logic                w_zeroext;
    logic                w_illegal_funct;

    mc_aludec #(
        .ALUCTL_W (ALUCTL_W)
    ) u_aludec (
        .i_aluop         (w_aluop),
        .i_op            (op),
        .i_funct         (funct),
        .o_alucontrol    (w_alucontrol),
        .o_zeroext       (w_zeroext),
        .o_illegal_funct (w_illegal_funct)
    );

    // An access is abandoned in the request cycle where the counter has
    // already reached MEM_TIMEOUT and memory is still not ready; a ready
    // in that same cycle completes the access instead.
    assign w_timeout = w_memreq && !mem_ready && (r_wait == WAIT_LIMIT);

    // Next-state and output decode
    always_comb begin
        w_next_state  = S_FETCH;
        w_memreq      = 1'b0;
        w_memwrite    = 1'b0;
        w_irwrite     = 1'b0;
        w_pcen        = 1'b0;
        w_regwrite    = 1'b0;
        w_aluop       = ALUOP_ADD;
        w_set_illegal = 1'b0;
        iord          = 1'b0;
        pcsrc         = PCSRC_ALURES;
        regdst        = REGDST_RT;
        memtoreg      = MEMTOREG_ALU;
        alusrca       = 1'b0;
        alusrcb       = SRCB_B;
        case (r_state)
            S_FETCH: begin
                w_memreq = 1'b1;
                alusrcb  = SRCB_FOUR;
                if (mem_ready) begin
                    w_irwrite    = 1'b1;
                    w_pcen       = 1'b1;
                    w_next_state = S_DECODE;
                end else if (w_timeout) begin
                    w_next_state = ABORT_STATE;
                end else begin
                    w_next_state = S_FETCH;
                end
            end
            S_DECODE: begin
                alusrcb = SRCB_IMM2;
                if (op_target(op) == S_FETCH) begin
                    w_set_illegal = 1'b1;
                    w_next_state  = ABORT_STATE;
                end else begin
                    w_next_state  = op_target(op);
                end
            end
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = SRCB_IMM;
                if (op == OP_LW) begin
                    w_next_state = S_MEMRD;
                end else begin
                    w_next_state = S_MEMWR;
                end
            end
            S_MEMRD: begin
                w_memreq = 1'b1;
                iord     = 1'b1;
                if (mem_ready) begin
                    w_next_state = S_MEMWB;
                end else if (w_timeout) begin
                    w_next_state = ABORT_STATE;
                end else begin
                    w_next_state = S_MEMRD;
                end
            end
            S_MEMWB: begin
                w_regwrite   = 1'b1;
                regdst       = REGDST_RT;
                memtoreg     = MEMTOREG_DATA;
                w_next_state = S_FETCH;
            end
            S_MEMWR: begin
                w_memreq   = 1'b1;
                w_memwrite = 1'b1;
                iord       = 1'b1;
                if (mem_ready) begin
                    w_next_state = S_FETCH;
                end else if (w_timeout) begin
                    w_next_state = ABORT_STATE;
                end else begin
                    w_next_state = S_MEMWR;
                end
            end
            S_EXEC: begin
                alusrca       = 1'b1;
                alusrcb       = SRCB_B;
                w_aluop       = ALUOP_FUNCT;
                w_set_illegal = w_illegal_funct;
                w_next_state  = S_ALUWB;
            end
            S_ALUWB: begin
                // funct is still held in IR, so a bad funct blocks the write here
                w_regwrite   = !w_illegal_funct;
                regdst       = REGDST_RD;
                memtoreg     = MEMTOREG_ALU;
                w_next_state = S_FETCH;
            end
            S_IEXEC: begin
                alusrca      = 1'b1;
                alusrcb      = SRCB_IMM;
                w_aluop      = ALUOP_IMM;
                w_next_state = S_IWB;
            end
            S_IWB: begin
                w_regwrite   = 1'b1;
                regdst       = REGDST_RT;
                memtoreg     = MEMTOREG_ALU;
                w_next_state = S_FETCH;
            end
            S_BRANCH: begin
                alusrca      = 1'b1;
                w_aluop      = ALUOP_SUB;
                pcsrc        = PCSRC_ALUOUT;
                w_pcen       = (op == OP_BEQ) ? zero : !zero;
                w_next_state = S_FETCH;
            end
            S_JUMP: begin
                pcsrc        = PCSRC_JUMP;
                w_pcen       = 1'b1;
                w_next_state = S_FETCH;
            end
            S_JAL: begin
                pcsrc        = PCSRC_JUMP;
                w_pcen       = 1'b1;
                w_regwrite   = 1'b1;
                regdst       = REGDST_R31;
                memtoreg     = MEMTOREG_PC;
                w_next_state = S_FETCH;
            end
            S_TRAP: begin
                pcsrc        = PCSRC_TRAP;
                w_pcen       = 1'b1;
                w_next_state = S_FETCH;
            end
            default: begin
                w_next_state = S_FETCH;
            end
        endcase
    end

    // Strobes are gated by reset so an in-flight access drops the instant
    // reset asserts, not at the next clock edge.
    assign memreq     = w_memreq   & reset;
    assign memwrite   = w_memwrite & reset;
    assign irwrite    = w_irwrite  & reset;
    assign pcen       = w_pcen     & reset;
    assign regwrite   = w_regwrite & reset;
    assign alucontrol = w_alucontrol;
    assign zeroext    = w_zeroext;
    assign bus_err    = r_bus_err;
    assign illegal    = r_illegal;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Memory wait counter: counts stalled request cycles, clears otherwise
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wait <= {WAIT_W{1'b0}};
        end else if (w_memreq && !mem_ready && !w_timeout) begin
            r_wait <= r_wait + WAIT_W'(1);
        end else begin
            r_wait <= {WAIT_W{1'b0}};
        end
    end

    // Sticky error flags, cleared only by reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_bus_err <= 1'b0;
            r_illegal <= 1'b0;
        end else begin
            r_bus_err <= r_bus_err | w_timeout;
            r_illegal <= r_illegal | w_set_illegal;
        end
    end

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// ---------------------------------------------------------------------------
// tb_mc_ctrl_fsm
// Instruction-level model: each instruction is expanded into the list of
// cycles it must take (fetch with waits, decode, class-specific phases),
// each cycle carrying its stimulus and the full expected output vector.
// The list is then played against the DUT and compared every cycle.
// ---------------------------------------------------------------------------
module tb_mc_ctrl_fsm;

    localparam int MEM_TIMEOUT  = 15;
    localparam int TRAP_VEC_SEL = 3;

    typedef struct packed {
        logic       memreq;
        logic       memwrite;
        logic       iord;
        logic       irwrite;
        logic       pcen;
        logic [1:0] pcsrc;
        logic       regwrite;
        logic [1:0] regdst;
        logic [1:0] memtoreg;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic       zeroext;
        logic [2:0] alucontrol;
        logic       bus_err;
        logic       illegal;
    } out_t;

    typedef struct packed {
        logic [5:0] op;
        logic [5:0] funct;
        logic       zero;
        logic       mem_ready;
        out_t       o;
    } cyc_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] op, funct;
    logic       zero, mem_ready;
    logic       memreq, memwrite, iord, irwrite, pcen, regwrite, alusrca, zeroext;
    logic       bus_err, illegal;
    logic [1:0] pcsrc, regdst, memtoreg, alusrcb;
    logic [2:0] alucontrol;
    out_t       dut_o;

    cyc_t       q[$];
    bit         m_bus_err, m_illegal;
    logic [5:0] g_op, g_funct;
    logic       g_zero;
    int         n_checks, n_errors, cyc_no;

    always #5 clk = ~clk;

    mc_ctrl_fsm #(
        .ALUCTL_W(3), .WAIT_W(4), .MEM_TIMEOUT(MEM_TIMEOUT), .TRAP_VEC_SEL(TRAP_VEC_SEL)
    ) dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .memreq(memreq), .memwrite(memwrite), .iord(iord),
        .irwrite(irwrite), .pcen(pcen), .pcsrc(pcsrc), .regwrite(regwrite),
        .regdst(regdst), .memtoreg(memtoreg), .alusrca(alusrca), .alusrcb(alusrcb),
        .zeroext(zeroext), .alucontrol(alucontrol), .bus_err(bus_err), .illegal(illegal)
    );

    assign dut_o = {memreq, memwrite, iord, irwrite, pcen, pcsrc, regwrite, regdst,
                    memtoreg, alusrca, alusrcb, zeroext, alucontrol, bus_err, illegal};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Idle cycle template: add in ALU, nothing enabled; mem_ready high to
    // show it is ignored when no access is requested.
    function automatic cyc_t base();
        cyc_t c = '0;
        c.op           = g_op;
        c.funct        = g_funct;
        c.zero         = g_zero;
        c.mem_ready    = 1'b1;
        c.o.alucontrol = 3'b010;
        return c;
    endfunction

    task automatic push(input cyc_t c);
        c.o.bus_err = m_bus_err;
        c.o.illegal = m_illegal;
        q.push_back(c);
    endtask

    task automatic trap_cycle();
`ifdef MC_TRAP_EN
        cyc_t c = base();
        c.o.pcen  = 1'b1;
        c.o.pcsrc = 2'(TRAP_VEC_SEL);
        push(c);
`endif
    endtask

    // kind: 0 fetch, 1 load, 2 store. waits = cycles memory holds ready low.
    // Memory may stall MEM_TIMEOUT full cycles; one more stalled cycle is the
    // abandon cycle, after which bus_err is set.
    task automatic mem_access(input int kind, input int waits, output bit done);
        int   n_low;
        cyc_t c;
        n_low = (waits > MEM_TIMEOUT) ? MEM_TIMEOUT + 1 : waits;
        c = base();
        c.o.memreq   = 1'b1;
        c.o.iord     = (kind != 0);
        c.o.memwrite = (kind == 2);
        if (kind == 0) c.o.alusrcb = 2'b01;
        c.mem_ready = 1'b0;
        for (int i = 0; i < n_low; i++) push(c);
        if (waits > MEM_TIMEOUT) begin
            m_bus_err = 1'b1;
            trap_cycle();
            done = 1'b0;
        end else begin
            c.mem_ready = 1'b1;
            if (kind == 0) begin
                c.o.irwrite = 1'b1;
                c.o.pcen    = 1'b1;
            end
            push(c);
            done = 1'b1;
        end
    endtask

    // {bad, alucontrol} for an R-type funct
    function automatic logic [3:0] funct_alu(input logic [5:0] f);
        case (f)
            6'b100000: return 4'b0010;
            6'b100010: return 4'b0110;
            6'b100100: return 4'b0000;
            6'b100101: return 4'b0001;
            6'b101010: return 4'b0111;
            default:   return 4'b1010;
        endcase
    endfunction

    task automatic gen_instr(input logic [5:0] o, input logic [5:0] f, input logic z,
                             input int fw, input int dw);
        bit         ok;
        cyc_t       c;
        logic [3:0] fa;
        g_op = o; g_funct = f; g_zero = z;
        mem_access(0, fw, ok);
        if (!ok) return;
        c = base(); c.o.alusrcb = 2'b11; push(c);
        case (o)
            6'b100011, 6'b101011: begin
                c = base(); c.o.alusrca = 1'b1; c.o.alusrcb = 2'b10; push(c);
                mem_access((o == 6'b100011) ? 1 : 2, dw, ok);
                if (ok && o == 6'b100011) begin
                    c = base(); c.o.regwrite = 1'b1; c.o.memtoreg = 2'b01; push(c);
                end
            end
            6'b000000: begin
                fa = funct_alu(f);
                c = base(); c.o.alusrca = 1'b1; c.o.alucontrol = fa[2:0]; push(c);
                if (fa[3]) m_illegal = 1'b1;
                c = base(); c.o.regdst = 2'b01; c.o.regwrite = !fa[3]; push(c);
            end
            6'b001000, 6'b001100, 6'b001101, 6'b001010: begin
                c = base(); c.o.alusrca = 1'b1; c.o.alusrcb = 2'b10;
                c.o.alucontrol = (o == 6'b001100) ? 3'b000 : (o == 6'b001101) ? 3'b001 :
                                 (o == 6'b001010) ? 3'b111 : 3'b010;
                c.o.zeroext = (o == 6'b001100) || (o == 6'b001101);
                push(c);
                c = base(); c.o.regwrite = 1'b1; push(c);
            end
            6'b000100, 6'b000101: begin
                c = base(); c.o.alusrca = 1'b1; c.o.alucontrol = 3'b110; c.o.pcsrc = 2'b01;
                c.o.pcen = (o == 6'b000100) ? z : !z;
                push(c);
            end
            6'b000010: begin
                c = base(); c.o.pcsrc = 2'b10; c.o.pcen = 1'b1; push(c);
            end
            6'b000011: begin
                c = base(); c.o.pcsrc = 2'b10; c.o.pcen = 1'b1; c.o.regwrite = 1'b1;
                c.o.regdst = 2'b10; c.o.memtoreg = 2'b10; push(c);
            end
            default: begin
                m_illegal = 1'b1;
                trap_cycle();
            end
        endcase
    endtask

    // Plays the queued cycles; entered and left at posedge+1.
    task automatic run_q();
        cyc_t c;
        while (q.size() > 0) begin
            c = q.pop_front();
            op = c.op; funct = c.funct; zero = c.zero; mem_ready = c.mem_ready;
            @(negedge clk);
            check($sformatf("cycle%0d", cyc_no), 32'(dut_o), 32'(c.o));
            cyc_no++;
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        bit   ok;
        cyc_t c;
        n_checks = 0; n_errors = 0; cyc_no = 0;
        m_bus_err = 1'b0; m_illegal = 1'b0;
        reset = 1'b0; op = 6'd0; funct = 6'd0; zero = 1'b0; mem_ready = 1'b0;

        @(negedge clk);
        check("rst_memreq", 32'(memreq), 32'd0);
        check("rst_fetch_srcb", 32'({iord, alusrca, alusrcb, alucontrol}), 32'({1'b0, 1'b0, 2'b01, 3'b010}));
        check("rst_flags", 32'({bus_err, illegal, irwrite, pcen}), 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;

        gen_instr(6'b000000, 6'b100000, 1'b0, 0, 0);
        check("model_r_len", q.size(), 32'd4);
        check("model_r_wb", 32'({q[3].o.regwrite, q[3].o.regdst}), 32'({1'b1, 2'b01}));
        run_q();

        gen_instr(6'b100011, 6'b000000, 1'b0, 0, 3);
        check("model_lw_len", q.size(), 32'd8);
        check("model_lw_wb", 32'({q[7].o.regwrite, q[7].o.memtoreg}), 32'({1'b1, 2'b01}));
        run_q();

        gen_instr(6'b101011, 6'b000000, 1'b0, 1, 0);
        check("model_sw_len", q.size(), 32'd5);
        run_q();

        gen_instr(6'b000101, 6'b000000, 1'b0, 0, 0);
        check("model_bne_taken", 32'({q[2].o.pcen, q[2].o.pcsrc}), 32'({1'b1, 2'b01}));
        run_q();
        gen_instr(6'b000101, 6'b000000, 1'b1, 0, 0);
        check("model_bne_not", 32'(q[2].o.pcen), 32'd0);
        run_q();
        gen_instr(6'b000100, 6'b000000, 1'b1, 0, 0); run_q();
        gen_instr(6'b000100, 6'b000000, 1'b0, 0, 0); run_q();

        gen_instr(6'b000011, 6'b000000, 1'b0, 0, 0);
        check("model_jal_len", q.size(), 32'd3);
        check("model_jal_c3", 32'({q[2].o.pcen, q[2].o.pcsrc, q[2].o.regwrite, q[2].o.regdst, q[2].o.memtoreg}),
              32'({1'b1, 2'b10, 1'b1, 2'b10, 2'b10}));
        run_q();
        gen_instr(6'b000010, 6'b000000, 1'b0, 2, 0); run_q();

        gen_instr(6'b001000, 6'b000000, 1'b0, 0, 0); run_q();
        gen_instr(6'b001100, 6'b000000, 1'b0, 0, 0);
        check("model_andi", 32'({q[2].o.zeroext, q[2].o.alucontrol}), 32'({1'b1, 3'b000}));
        run_q();
        gen_instr(6'b001101, 6'b000000, 1'b0, 0, 0); run_q();
        gen_instr(6'b001010, 6'b000000, 1'b0, 0, 0); run_q();
        gen_instr(6'b000000, 6'b100010, 1'b0, 0, 0); run_q();
        gen_instr(6'b000000, 6'b100100, 1'b0, 0, 0); run_q();
        gen_instr(6'b000000, 6'b100101, 1'b0, 0, 0); run_q();
        gen_instr(6'b000000, 6'b101010, 1'b0, 0, 0); run_q();

        // bad funct: illegal set, no register write
        gen_instr(6'b000000, 6'b111111, 1'b0, 0, 0); run_q();
        // ready arriving in the very cycle the timeout would fire
        gen_instr(6'b000000, 6'b100000, 1'b0, MEM_TIMEOUT, 0);
        check("model_ready_wins_len", q.size(), 32'(MEM_TIMEOUT + 4));
        run_q();
        // unknown opcode
        m_illegal = 1'b0;
        reset = 1'b0; #1; reset = 1'b1;
        check("illegal_cleared", 32'(illegal), 32'd0);
        gen_instr(6'b111111, 6'b000000, 1'b0, 0, 0); run_q();
        gen_instr(6'b000010, 6'b000000, 1'b0, 0, 0); run_q();

        // fetch timeout
        gen_instr(6'b000000, 6'b100000, 1'b0, 40, 0);
`ifdef MC_TRAP_EN
        check("model_fetch_to_len", q.size(), 32'(MEM_TIMEOUT + 2));
`else
        check("model_fetch_to_len", q.size(), 32'(MEM_TIMEOUT + 1));
`endif
        run_q();
        // load data timeout, then a normal instruction
        gen_instr(6'b100011, 6'b000000, 1'b0, 0, 40); run_q();
        gen_instr(6'b000000, 6'b100000, 1'b0, 0, 0); run_q();

        // reset in the middle of a stalled store
        g_op = 6'b101011; g_funct = 6'd0; g_zero = 1'b0;
        mem_access(0, 0, ok);
        c = base(); c.o.alusrcb = 2'b11; push(c);
        c = base(); c.o.alusrca = 1'b1; c.o.alusrcb = 2'b10; push(c);
        c = base(); c.o.memreq = 1'b1; c.o.memwrite = 1'b1; c.o.iord = 1'b1; c.mem_ready = 1'b0;
        push(c);
        run_q();
        #2;
        check("pre_rst_memwrite", 32'({memreq, memwrite}), 32'({1'b1, 1'b1}));
        reset = 1'b0;
        #1;
        check("midrst_memreq", 32'({memreq, memwrite}), 32'd0);
        check("midrst_flags", 32'({bus_err, illegal}), 32'd0);
        check("midrst_fetch", 32'({iord, alusrcb}), 32'({1'b0, 2'b01}));
        @(posedge clk); #1;
        reset = 1'b1;
        m_bus_err = 1'b0; m_illegal = 1'b0;
        gen_instr(6'b000000, 6'b100000, 1'b0, 1, 0); run_q();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
